// File: rtl/hazard_pkg.sv
// hazard_pkg: shared scoreboard entry type, forwarding encoding and helpers
package hazard_pkg;
    // Widest register address the scoreboard stores; narrower addresses are zero-extended.
    localparam int SB_RD_W = 8;
    localparam logic [2:0] FWD_RF = 3'd0;

    typedef struct packed {
        logic               v;
        logic [SB_RD_W-1:0] rd;
        logic               wr;
        logic               ld;
    } sb_entry_t;

    function automatic logic [2:0] sel_of(input int idx);
        return 3'(idx + 1);
    endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping
//   clk, rst (async, active-low) ; inc: count this cycle ; q: current count
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);
    always_ff @(posedge clk or negedge rst)
        if (!rst)
            q <= '0;
        else if (inc && q != '1)
            q <= q + 1'b1;
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: ID-stage stall/flush/forwarding unit driven by a shift-register scoreboard
//   clk, rst (async, active-low)
//   id_*      : decoded instruction in ID ; br_taken: branch resolved taken in ID
//   stall     : hold PC and IF/ID ; flush_if: clear IF/ID ; bubble_ex: clear ID/EX
//   fwd_sel1/2: 0 = regfile, k = scoreboard entry k-1
//   stall_cnt, flush_cnt: saturating event counters
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int NUM_STAGES = 2,
    parameter int LOAD_LAT   = 1,
    parameter bit FWD_EN     = 1'b1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use1,
    input  logic              id_use2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              br_taken,
    output logic              stall,
    output logic              flush_if,
    output logic              bubble_ex,
    output logic [2:0]        fwd_sel1,
    output logic [2:0]        fwd_sel2,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);
    sb_entry_t          sb [NUM_STAGES];
    logic [SB_RD_W-1:0] rs1_x, rs2_x;
    logic               hit, m1, m2;
    logic [2:0]         sel1, sel2;

    assign rs1_x = SB_RD_W'(id_rs1);
    assign rs2_x = SB_RD_W'(id_rs2);

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            for (int k = 0; k < NUM_STAGES; k++)
                sb[k] <= '0;
        end else begin
            for (int k = NUM_STAGES - 1; k > 0; k--)
                sb[k] <= sb[k-1];
            sb[0] <= (stall || !id_valid) ? '0 : sb_entry_t'{1'b1, SB_RD_W'(id_rd), id_regwrite, id_memread};
        end

    // Walk oldest to youngest so the youngest match is the last one written.
    always_comb begin
        hit  = 1'b0;
        sel1 = FWD_RF;
        sel2 = FWD_RF;
        m1   = 1'b0;
        m2   = 1'b0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            m1 = sb[i].v && sb[i].wr && sb[i].rd != '0 && sb[i].rd == rs1_x && id_use1;
            m2 = sb[i].v && sb[i].wr && sb[i].rd != '0 && sb[i].rd == rs2_x && id_use2;
            if (m1) sel1 = sel_of(i);
            if (m2) sel2 = sel_of(i);
            if ((m1 || m2) && (!FWD_EN || (i < LOAD_LAT && sb[i].ld))) hit = 1'b1;
        end
    end

    assign stall     = id_valid && hit;
    assign bubble_ex = stall;
    // rst gating keeps a branch in ID from flushing while the unit is held in reset.
    assign flush_if  = rst && id_valid && br_taken && !stall;
    assign fwd_sel1  = (FWD_EN && id_valid && !stall) ? sel1 : FWD_RF;
    assign fwd_sel2  = (FWD_EN && id_valid && !stall) ? sel2 : FWD_RF;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (.clk(clk), .rst(rst), .inc(stall),    .q(stall_cnt));
    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (.clk(clk), .rst(rst), .inc(flush_if), .q(flush_cnt));
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: four configurations of hazard_scoreboard checked against an instruction-history model
module tb_hazard_scoreboard;
    typedef struct {bit v; int rd; bit wr; bit ld;} ins_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic id_valid = 1'b0, id_use1 = 1'b0, id_use2 = 1'b0;
    logic id_regwrite = 1'b0, id_memread = 1'b0, br_taken = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic [3:0] st_o, fl_o, bx_o;
    logic [3:0][2:0] f1_o, f2_o;
    logic [3:0][15:0] sc_o, fc_o;

    int n_chk = 0;
    int n_fail = 0;
    // configs: 0 defaults, 1 no-forwarding, 2 4-bit counters, 3 deeper pipe with 2-cycle loads
    int ns[4]   = '{2, 2, 2, 3};
    int ll[4]   = '{1, 1, 1, 2};
    bit fe[4]   = '{1'b1, 1'b0, 1'b1, 1'b1};
    int cmax[4] = '{65535, 65535, 15, 65535};
    ins_t hist[4][4];
    int ms[4], mf[4];

    always #5 clk = ~clk;

    hazard_scoreboard #(.REG_AW(5), .NUM_STAGES(2), .LOAD_LAT(1), .FWD_EN(1'b1), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use1(id_use1), .id_use2(id_use2), .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .br_taken(br_taken), .stall(st_o[0]), .flush_if(fl_o[0]),
        .bubble_ex(bx_o[0]), .fwd_sel1(f1_o[0]), .fwd_sel2(f2_o[0]),
        .stall_cnt(sc_o[0]), .flush_cnt(fc_o[0]));

    hazard_scoreboard #(.REG_AW(5), .NUM_STAGES(2), .LOAD_LAT(1), .FWD_EN(1'b0), .CNT_W(16)) u_b (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use1(id_use1), .id_use2(id_use2), .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .br_taken(br_taken), .stall(st_o[1]), .flush_if(fl_o[1]),
        .bubble_ex(bx_o[1]), .fwd_sel1(f1_o[1]), .fwd_sel2(f2_o[1]),
        .stall_cnt(sc_o[1]), .flush_cnt(fc_o[1]));

    hazard_scoreboard #(.REG_AW(5), .NUM_STAGES(2), .LOAD_LAT(1), .FWD_EN(1'b1), .CNT_W(4)) u_c (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use1(id_use1), .id_use2(id_use2), .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .br_taken(br_taken), .stall(st_o[2]), .flush_if(fl_o[2]),
        .bubble_ex(bx_o[2]), .fwd_sel1(f1_o[2]), .fwd_sel2(f2_o[2]),
        .stall_cnt(sc_o[2][3:0]), .flush_cnt(fc_o[2][3:0]));
    assign sc_o[2][15:4] = '0;
    assign fc_o[2][15:4] = '0;

    hazard_scoreboard #(.REG_AW(5), .NUM_STAGES(3), .LOAD_LAT(2), .FWD_EN(1'b1), .CNT_W(16)) u_d (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use1(id_use1), .id_use2(id_use2), .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .br_taken(br_taken), .stall(st_o[3]), .flush_if(fl_o[3]),
        .bubble_ex(bx_o[3]), .fwd_sel1(f1_o[3]), .fwd_sel2(f2_o[3]),
        .stall_cnt(sc_o[3]), .flush_cnt(fc_o[3]));

    // Reference: look back over the last ns[c] issued instructions (index 0 = most recent).
    function automatic void model_eval(input int c, output bit st, output bit fl, output int f1, output int f2);
        int y1 = -1;
        int y2 = -1;
        bit hit = 1'b0;
        for (int i = 0; i < ns[c]; i++) begin
            bit w = hist[c][i].v && hist[c][i].wr && hist[c][i].rd != 0;
            bit a = w && id_use1 && hist[c][i].rd == int'(id_rs1);
            bit b = w && id_use2 && hist[c][i].rd == int'(id_rs2);
            if (a && y1 < 0) y1 = i;
            if (b && y2 < 0) y2 = i;
            if ((a || b) && (!fe[c] || (i < ll[c] && hist[c][i].ld))) hit = 1'b1;
        end
        st = rst && id_valid && hit;
        fl = rst && id_valid && br_taken && !st;
        f1 = (fe[c] && id_valid && !st && y1 >= 0) ? y1 + 1 : 0;
        f2 = (fe[c] && id_valid && !st && y2 >= 0) ? y2 + 1 : 0;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            ms[c] = 0;
            mf[c] = 0;
            for (int k = 0; k < 4; k++) hist[c][k] = '{0, 0, 0, 0};
        end
    endtask

    task automatic tick();
        bit st[4], fl[4];
        int d1, d2;
        for (int c = 0; c < 4; c++) model_eval(c, st[c], fl[c], d1, d2);
        @(posedge clk);
        for (int c = 0; c < 4; c++) begin
            if (st[c] && ms[c] < cmax[c]) ms[c]++;
            if (fl[c] && mf[c] < cmax[c]) mf[c]++;
            for (int k = ns[c] - 1; k > 0; k--) hist[c][k] = hist[c][k-1];
            hist[c][0] = (st[c] || !id_valid) ? '{0, 0, 0, 0} : '{1, int'(id_rd), id_regwrite, id_memread};
        end
        #1;
    endtask

    task automatic set_ins(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                           input int rd, input bit wr, input bit ld, input bit br);
        id_valid = v; id_rs1 = 5'(rs1); id_use1 = u1; id_rs2 = 5'(rs2); id_use2 = u2;
        id_rd = 5'(rd); id_regwrite = wr; id_memread = ld; br_taken = br;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        set_ins(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set_ins(1, 3, 1, 4, 1, 5, 1, 1, 1);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int c = 0; c < 4; c++) begin
            n_chk++;
            if ({st_o[c], fl_o[c], bx_o[c], f1_o[c], f2_o[c], sc_o[c], fc_o[c]} !== '0) begin
                n_fail++;
                $display("FAIL reset_cfg%0d: st=%b fl=%b bx=%b f1=%0d f2=%0d sc=%0d fc=%0d, all must be 0",
                         c, st_o[c], fl_o[c], bx_o[c], f1_o[c], f2_o[c], sc_o[c], fc_o[c]);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_forward();
        do_reset();
        set_ins(1, 1, 1, 2, 1, 5, 1, 0, 0);
        tick();
        set_ins(1, 5, 1, 3, 1, 6, 1, 0, 0);
        n_chk++;
        if (f1_o[0] !== 3'd1 || f2_o[0] !== 3'd0 || st_o[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL fwd_adjacent: f1=%0d f2=%0d st=%b, want f1=1 f2=0 st=0", f1_o[0], f2_o[0], st_o[0]);
        end
        tick();
        set_ins(1, 11, 1, 12, 1, 10, 1, 0, 0);
        tick();
        set_ins(1, 6, 1, 0, 1, 13, 1, 0, 0);
        n_chk++;
        if (f1_o[0] !== 3'd2 || f2_o[0] !== 3'd0 || st_o[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL fwd_gap: f1=%0d f2=%0d st=%b, want f1=2 f2=0 st=0", f1_o[0], f2_o[0], st_o[0]);
        end
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        set_ins(1, 0, 1, 0, 0, 7, 1, 1, 0);
        tick();
        set_ins(1, 7, 1, 7, 1, 8, 1, 0, 0);
        n_chk++;
        if (st_o[0] !== 1'b1 || bx_o[0] !== 1'b1 || f1_o[0] !== 3'd0 || f2_o[0] !== 3'd0) begin
            n_fail++;
            $display("FAIL load_use_stall: st=%b bx=%b f1=%0d f2=%0d, want 1 1 0 0", st_o[0], bx_o[0], f1_o[0], f2_o[0]);
        end
        tick();
        n_chk++;
        if (st_o[0] !== 1'b0 || bx_o[0] !== 1'b0 || f1_o[0] !== 3'd2 || f2_o[0] !== 3'd2 || sc_o[0] !== 16'd1) begin
            n_fail++;
            $display("FAIL load_use_release: st=%b bx=%b f1=%0d f2=%0d sc=%0d, want 0 0 2 2 1",
                     st_o[0], bx_o[0], f1_o[0], f2_o[0], sc_o[0]);
        end
        tick();
    endtask

    task automatic test_x0();
        do_reset();
        set_ins(1, 1, 1, 0, 0, 0, 1, 0, 0);
        tick();
        set_ins(1, 0, 1, 0, 1, 4, 1, 0, 0);
        n_chk++;
        if (f1_o[0] !== 3'd0 || f2_o[0] !== 3'd0 || st_o[0] !== 1'b0 || st_o[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL x0_no_hazard: f1=%0d f2=%0d st=%b st_nofwd=%b, want 0 0 0 0", f1_o[0], f2_o[0], st_o[0], st_o[1]);
        end
        tick();
    endtask

    task automatic test_branch();
        do_reset();
        set_ins(1, 1, 1, 2, 1, 0, 0, 0, 1);
        n_chk++;
        if (fl_o[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL branch_flush: fl=%b want 1", fl_o[0]);
        end
        tick();
        set_ins(1, 0, 1, 0, 0, 7, 1, 1, 0);
        n_chk++;
        if (fl_o[0] !== 1'b0 || fc_o[0] !== 16'd1) begin
            n_fail++;
            $display("FAIL branch_once: fl=%b fc=%0d, want 0 1", fl_o[0], fc_o[0]);
        end
        tick();
        set_ins(1, 7, 1, 7, 1, 0, 0, 0, 1);
        n_chk++;
        if (st_o[0] !== 1'b1 || fl_o[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL branch_during_stall: st=%b fl=%b, want 1 0", st_o[0], fl_o[0]);
        end
        tick();
        n_chk++;
        if (st_o[0] !== 1'b0 || fl_o[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL branch_after_stall: st=%b fl=%b, want 0 1", st_o[0], fl_o[0]);
        end
        tick();
        set_ins(0, 0, 0, 0, 0, 0, 0, 0, 0);
        n_chk++;
        if (fc_o[0] !== 16'd2) begin
            n_fail++;
            $display("FAIL branch_count: fc=%0d want 2", fc_o[0]);
        end
    endtask

    task automatic test_no_fwd();
        do_reset();
        set_ins(1, 1, 1, 0, 0, 9, 1, 0, 0);
        tick();
        set_ins(1, 9, 1, 9, 1, 10, 1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (st_o[1] !== (k < 2) || f1_o[1] !== 3'd0 || f2_o[1] !== 3'd0) begin
                n_fail++;
                $display("FAIL nofwd_cycle%0d: st=%b f1=%0d f2=%0d, want st=%b f1=0 f2=0", k, st_o[1], f1_o[1], f2_o[1], k < 2);
            end
            tick();
        end
        n_chk++;
        if (sc_o[1] !== 16'd2) begin
            n_fail++;
            $display("FAIL nofwd_count: sc=%0d want 2", sc_o[1]);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int k = 0; k < 20; k++) begin
            set_ins(1, 0, 1, 0, 0, 7, 1, 1, 0);
            tick();
            set_ins(1, 7, 1, 0, 0, 8, 1, 0, 0);
            n_chk++;
            if (st_o[2] !== 1'b1) begin
                n_fail++;
                $display("FAIL sat_stall%0d: st=%b want 1", k, st_o[2]);
            end
            tick();
            tick();
        end
        n_chk++;
        if (sc_o[2] !== 16'd15 || sc_o[0] !== 16'd20) begin
            n_fail++;
            $display("FAIL sat_hold: sc4=%0d sc16=%0d, want 15 20", sc_o[2], sc_o[0]);
        end
        set_ins(1, 0, 1, 0, 0, 7, 1, 1, 1);
        tick();
        set_ins(1, 7, 1, 0, 0, 8, 1, 0, 1);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        for (int c = 0; c < 4; c++) begin
            n_chk++;
            if ({st_o[c], fl_o[c], bx_o[c], f1_o[c], f2_o[c], sc_o[c], fc_o[c]} !== '0) begin
                n_fail++;
                $display("FAIL async_reset_cfg%0d: st=%b fl=%b bx=%b sc=%0d fc=%0d, all must be 0",
                         c, st_o[c], fl_o[c], bx_o[c], sc_o[c], fc_o[c]);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_random();
        bit es, ef;
        int e1, e2;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            set_ins($urandom_range(0, 9) < 8, $urandom_range(0, 3), $urandom_range(0, 1),
                    $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
                    $urandom_range(0, 3) < 3, $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0);
            for (int c = 0; c < 4; c++) begin
                model_eval(c, es, ef, e1, e2);
                n_chk++;
                if ({st_o[c], bx_o[c], fl_o[c], f1_o[c], f2_o[c]} !== {es, es, ef, 3'(e1), 3'(e2)}) begin
                    n_fail++;
                    $display("FAIL rand_cfg%0d_cyc%0d: st=%b bx=%b fl=%b f1=%0d f2=%0d, want st=%b bx=%b fl=%b f1=%0d f2=%0d",
                             c, n, st_o[c], bx_o[c], fl_o[c], f1_o[c], f2_o[c], es, es, ef, e1, e2);
                end
            end
            tick();
            for (int c = 0; c < 4; c++) begin
                n_chk++;
                if (sc_o[c] !== 16'(ms[c]) || fc_o[c] !== 16'(mf[c])) begin
                    n_fail++;
                    $display("FAIL rand_cnt_cfg%0d_cyc%0d: sc=%0d fc=%0d, want sc=%0d fc=%0d", c, n, sc_o[c], fc_o[c], ms[c], mf[c]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_x0();
        test_branch();
        test_no_fwd();
        test_saturate();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
